// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 blocks of 4 bytes.
// CPU hits are served from IDLE with no stall. A miss evicts a dirty victim
// (WRITEBACK) and then fills the block (FETCH). The request is then replayed
// in IDLE as a hit.
`timescale 1ns/1ps

module data_cache (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [7:0]  address_i,
    input  logic [7:0]  writedata_i,
    output logic [7:0]  readdata_o,
    output logic        busywait_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [5:0]  mem_address_o,
    output logic [31:0] mem_writedata_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_busywait_i
);

    typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

    state_e      state_q;
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];

    logic        mem_read_q;
    logic        mem_write_q;
    logic [5:0]  mem_address_q;
    logic [31:0] mem_writedata_q;

    logic [2:0]  addr_tag;
    logic [2:0]  addr_idx;
    logic [1:0]  addr_off;
    logic        req;
    logic        hit;
    logic        fill_done;
    logic [31:0] cur_block;

    assign addr_tag  = address_i[7:5];
    assign addr_idx  = address_i[4:2];
    assign addr_off  = address_i[1:0];
    assign req       = read_i | write_i;
    // Invalid entries never hit, so the uninitialised tag array is harmless.
    assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign fill_done = (state_q == StFetch) && !mem_busywait_i;
    assign cur_block = data_q[addr_idx];

    assign readdata_o      = cur_block[{addr_off, 3'b000} +: 8];
    assign busywait_o      = (state_q != StIdle) || (req && !hit);
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_address_o   = mem_address_q;
    assign mem_writedata_o = mem_writedata_q;

    // Controller: state, valid/dirty bits and registered memory-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            dirty_q         <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        if (hit) begin
                            // Write takes priority when both READ and WRITE are high.
                            if (write_i) begin
                                dirty_q[addr_idx] <= 1'b1;
                            end
                        end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                            state_q         <= StWriteback;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {tag_q[addr_idx], addr_idx};
                            mem_writedata_q <= data_q[addr_idx];
                        end else begin
                            state_q       <= StFetch;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= address_i[7:2];
                        end
                    end
                end
                StWriteback: begin
                    if (!mem_busywait_i) begin
                        state_q       <= StFetch;
                        mem_write_q   <= 1'b0;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= address_i[7:2];
                    end
                end
                StFetch: begin
                    if (!mem_busywait_i) begin
                        state_q           <= StIdle;
                        mem_read_q        <= 1'b0;
                        valid_q[addr_idx] <= 1'b1;
                        dirty_q[addr_idx] <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays: byte merge on a write hit, whole-block load on fill.
    always_ff @(posedge clk_i) begin
        if ((state_q == StIdle) && write_i && hit) begin
            data_q[addr_idx][{addr_off, 3'b000} +: 8] <= writedata_i;
        end else if (fill_done) begin
            data_q[addr_idx] <= mem_readdata_i;
            tag_q[addr_idx]  <= addr_tag;
        end
    end

endmodule
